// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the RAM.
interface mem_arbiter_if;
    localparam int unsigned DW = 32;

    // Instruction requester
    logic          iREN;
    logic [DW-1:0] iaddr;
    logic          iwait;
    logic [DW-1:0] iload;

    // Data requester
    logic          dREN;
    logic          dWEN;
    logic [DW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dwait;
    logic [DW-1:0] dload;

    // RAM side
    logic          ramREN;
    logic          ramWEN;
    logic [DW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;

    // Sticky error flag
    logic          fault;

    // Arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, fault
    );

    // Environment view (requesters + RAM)
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, fault
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single-port RAM.
// Alternating priority on ties, grant timeout, sticky fault reporting.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  io_bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_lastgnt_d;   // 1: data was served last, 0: instruction
    logic            r_fault;
    logic            r_fault_d;     // side that faulted, 1: data
    logic [CW-1:0]   r_cnt;

    state_t          w_state_eff;
    logic            w_i_req;
    logic            w_d_req;
    logic            w_access;
    logic            w_error;
    logic            w_expire;
    logic            w_g_is_d;
    logic            w_g_req;

    logic            w_ramREN;
    logic            w_ramWEN;
    logic [DW-1:0]   w_ramaddr;
    logic [DW-1:0]   w_ramstore;
    logic            w_iwait;
    logic            w_dwait;
    logic [DW-1:0]   w_iload;
    logic [DW-1:0]   w_dload;

    assign w_i_req  = io_bus.iREN;
    assign w_d_req  = io_bus.dREN | io_bus.dWEN;
    assign w_access = (io_bus.ramstate == RS_ACCESS);
    assign w_error  = (io_bus.ramstate == RS_ERROR);
    assign w_expire = (r_cnt == CW'(TIMEOUT - 1));
    assign w_g_is_d = (r_state == ST_GNT_D);
    assign w_g_req  = w_g_is_d ? w_d_req : w_i_req;

    // Reset forces idle-state outputs in the very cycle it is sampled high
    assign w_state_eff = RST ? ST_IDLE : r_state;

    // Output decode: RAM strobes and loads follow the granted requester's live inputs
    always_comb begin
        w_ramREN   = 1'b0;
        w_ramWEN   = 1'b0;
        w_ramaddr  = '0;
        w_ramstore = '0;
        w_iwait    = w_i_req;
        w_dwait    = w_d_req;
        w_iload    = '0;
        w_dload    = '0;
        case (w_state_eff)
            ST_GNT_I: begin
                w_ramREN  = io_bus.iREN;
                w_ramaddr = io_bus.iaddr;
                w_iwait   = w_i_req & ~w_access;
                if (w_i_req && w_access) begin
                    w_iload = io_bus.ramload;
                end
            end
            ST_GNT_D: begin
                w_ramREN   = io_bus.dREN;
                w_ramWEN   = io_bus.dWEN;
                w_ramaddr  = io_bus.daddr;
                w_ramstore = io_bus.dstore;
                w_dwait    = w_d_req & ~w_access;
                if (w_d_req && w_access) begin
                    w_dload = io_bus.ramload;
                end
            end
            ST_FAULT: begin
                // Release the faulted requester with the error word
                if (r_fault_d) begin
                    w_dwait = 1'b0;
                    w_dload = ERRWORD;
                end else begin
                    w_iwait = 1'b0;
                    w_iload = ERRWORD;
                end
            end
            default: begin
            end
        endcase
    end

    assign io_bus.ramREN   = w_ramREN;
    assign io_bus.ramWEN   = w_ramWEN;
    assign io_bus.ramaddr  = w_ramaddr;
    assign io_bus.ramstore = w_ramstore;
    assign io_bus.iwait    = w_iwait;
    assign io_bus.dwait    = w_dwait;
    assign io_bus.iload    = w_iload;
    assign io_bus.dload    = w_dload;
    assign io_bus.fault    = r_fault;

    // Arbitration state machine, grant timer and sticky fault flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_lastgnt_d <= 1'b0;
            r_cnt       <= '0;
            r_fault     <= 1'b0;
            r_fault_d   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie, serve the side that was not served last
                    if (w_d_req && (!w_i_req || !r_lastgnt_d)) begin
                        r_state <= ST_GNT_D;
                    end else if (w_i_req) begin
                        r_state <= ST_GNT_I;
                    end
                    r_cnt <= '0;
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (!w_g_req) begin
                        // Requester withdrew: drop the grant, history untouched
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_access) begin
                        r_state     <= ST_IDLE;
                        r_lastgnt_d <= w_g_is_d;
                        r_cnt       <= '0;
                    end else if (w_error || w_expire) begin
                        r_state   <= ST_FAULT;
                        r_fault   <= 1'b1;
                        r_fault_d <= w_g_is_d;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_FAULT: begin
                    r_lastgnt_d <= r_fault_d;
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a load scoreboard.
module tb_mem_arbiter;
    localparam logic [31:0] ERRWORD   = 32'hBAD1BAD1;
    localparam logic [31:0] KEY       = 32'hA5A5_0000;
    localparam logic [1:0]  RS_FREE   = 2'd0;
    localparam logic [1:0]  RS_BUSY   = 2'd1;
    localparam logic [1:0]  RS_ACCESS = 2'd2;
    localparam logic [1:0]  RS_ERROR  = 2'd3;

    typedef struct {
        bit          is_d;
        logic [31:0] load;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        use_model;
    logic [31:0] tb_ramload;
    logic [1:0]  tb_ramstate;
    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        sb[$];

    mem_arbiter_if bus();

    // RAM stand-in: either a fixed word or an address-derived word
    assign bus.ramload  = use_model ? (bus.ramaddr ^ KEY) : tb_ramload;
    assign bus.ramstate = tb_ramstate;

    mem_arbiter #(
        .TIMEOUT (16),
        .ERRWORD (32'hBAD1BAD1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic push(input bit is_d, input logic [31:0] load);
        exp_t e;
        e.is_d = is_d;
        e.load = load;
        sb.push_back(e);
    endtask

    // Compare the completing side and its load against the oldest expectation
    task automatic sb_check(input string tag);
        exp_t        e;
        logic        obs_d;
        logic [31:0] obs_load;
        obs_d    = (bus.dREN | bus.dWEN) & ~bus.dwait;
        obs_load = obs_d ? bus.dload : bus.iload;
        chkb({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chkb({tag, "_side"}, obs_d, e.is_d);
            chk({tag, "_load"}, obs_load, e.load);
        end
    endtask

    initial begin
        int          wen_cycles;
        logic        iw_held;
        int          g;
        int          done;
        int          cycles;
        int          idx_d;
        int          idx_i;
        logic        comp_d;
        logic        comp_i;
        logic [31:0] a_d;
        logic [31:0] a_i;

        // Reset: idle outputs, iwait mirrors iREN even while in reset
        RST = 1'b1; use_model = 1'b0; tb_ramload = '0; tb_ramstate = RS_FREE;
        bus.iREN = 1'b1; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0;
        cyc(); cyc();
        mid();
        chkb("rst_iwait", bus.iwait, 1'b1);
        chkb("rst_dwait", bus.dwait, 1'b0);
        chkb("rst_ramREN", bus.ramREN, 1'b0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chkb("rst_fault", bus.fault, 1'b0);
        cyc(); RST = 1'b0; bus.iREN = 1'b0;

        // T1: single instruction fetch, 2-cycle latency
        bus.iREN = 1'b1; bus.iaddr = 32'h40; tb_ramstate = RS_ACCESS; tb_ramload = 32'h8C010004;
        push(1'b0, 32'h8C010004);
        mid();
        chkb("t1_c1_iwait", bus.iwait, 1'b1);
        chkb("t1_c1_ramREN", bus.ramREN, 1'b0);
        chk("t1_c1_iload", bus.iload, 32'h0);
        cyc(); mid();
        chkb("t1_c2_ramREN", bus.ramREN, 1'b1);
        chk("t1_c2_ramaddr", bus.ramaddr, 32'h40);
        chkb("t1_c2_iwait", bus.iwait, 1'b0);
        sb_check("t1");
        cyc(); bus.iREN = 1'b0;
        mid();
        chkb("t1_idle_ramREN", bus.ramREN, 1'b0);
        chk("t1_idle_iload", bus.iload, 32'h0);

        // T2: simultaneous iREN/dWEN, data first, then instruction
        cyc();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
        tb_ramstate = RS_BUSY; tb_ramload = 32'h1234;
        mid();
        chkb("t2_idle_ramWEN", bus.ramWEN, 1'b0);
        chkb("t2_idle_dwait", bus.dwait, 1'b1);
        wen_cycles = 0; iw_held = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 2) tb_ramstate = RS_ACCESS;
            mid();
            if (bus.ramWEN) wen_cycles++;
            iw_held &= bus.iwait;
            chk("t2_ramaddr", bus.ramaddr, 32'h100);
            chk("t2_ramstore", bus.ramstore, 32'hDEAD);
        end
        chk("t2_wen_cycles", 32'(wen_cycles), 32'd3);
        chkb("t2_iwait_held", iw_held, 1'b1);
        chkb("t2_dwait_done", bus.dwait, 1'b0);
        cyc(); bus.dWEN = 1'b0;
        push(1'b0, 32'h1234);
        mid();
        chkb("t2_idle2_ramWEN", bus.ramWEN, 1'b0);
        chkb("t2_idle2_ramREN", bus.ramREN, 1'b0);
        chkb("t2_idle2_iwait", bus.iwait, 1'b1);
        cyc(); mid();
        chkb("t2_gi_ramREN", bus.ramREN, 1'b1);
        chk("t2_gi_ramaddr", bus.ramaddr, 32'h80);
        sb_check("t2");
        cyc(); bus.iREN = 1'b0;

        // T3: both requesting continuously, 8 accesses alternate D,I,...
        use_model = 1'b1; tb_ramstate = RS_ACCESS;
        for (int k = 0; k < 4; k++) begin
            a_d = 32'h1000 + 32'(k * 4);
            a_i = 32'h2000 + 32'(k * 4);
            push(1'b1, a_d ^ KEY);
            push(1'b0, a_i ^ KEY);
        end
        idx_d = 0; idx_i = 0; done = 0; cycles = 0;
        bus.dREN = 1'b1; bus.daddr = 32'h1000;
        bus.iREN = 1'b1; bus.iaddr = 32'h2000;
        while (done < 8 && cycles < 40) begin
            mid();
            comp_d = bus.dREN & ~bus.dwait;
            comp_i = bus.iREN & ~bus.iwait;
            if (comp_d || comp_i) begin
                sb_check("t3");
                done++;
            end
            cyc();
            cycles++;
            if (comp_d) begin
                idx_d++;
                if (idx_d < 4) bus.daddr = 32'h1000 + 32'(idx_d * 4);
                else bus.dREN = 1'b0;
            end
            if (comp_i) begin
                idx_i++;
                if (idx_i < 4) bus.iaddr = 32'h2000 + 32'(idx_i * 4);
                else bus.iREN = 1'b0;
            end
        end
        chk("t3_done", 32'(done), 32'd8);
        chk("t3_cycles", 32'(cycles), 32'd16);
        bus.dREN = 1'b0; bus.iREN = 1'b0;
        use_model = 1'b0;

        // T4: data read with RAM stuck BUSY times out into FAULT
        bus.dREN = 1'b1; bus.daddr = 32'h200; tb_ramstate = RS_BUSY;
        push(1'b1, ERRWORD);
        mid();
        chkb("t4_idle_dwait", bus.dwait, 1'b1);
        g = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(); mid();
            if (bus.ramREN && bus.dwait && bus.dload == 32'h0) g++;
        end
        chk("t4_grant_cycles", 32'(g), 32'd16);
        cyc(); mid();
        chkb("t4_f_ramREN", bus.ramREN, 1'b0);
        chkb("t4_f_dwait", bus.dwait, 1'b0);
        chkb("t4_f_fault", bus.fault, 1'b1);
        sb_check("t4");
        cyc(); bus.dREN = 1'b0;
        mid();
        chk("t4_after_dload", bus.dload, 32'h0);
        chkb("t4_after_fault", bus.fault, 1'b1);
        cyc();
        bus.iREN = 1'b1; bus.iaddr = 32'h300; tb_ramstate = RS_ACCESS; tb_ramload = 32'h55;
        push(1'b0, 32'h55);
        mid();
        chkb("t4_i_idle_iwait", bus.iwait, 1'b1);
        cyc(); mid();
        sb_check("t4_i");
        chkb("t4_i_fault", bus.fault, 1'b1);
        cyc(); bus.iREN = 1'b0;

        // T5: make data the last served side, then reset in the middle of a write
        bus.dREN = 1'b1; bus.daddr = 32'h340; tb_ramload = 32'h66;
        push(1'b1, 32'h66);
        mid();
        cyc(); mid();
        sb_check("t5_d");
        cyc(); bus.dREN = 1'b0;
        bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'hBEEF; tb_ramstate = RS_BUSY;
        mid();
        cyc(); mid();
        chkb("t5_gd_ramWEN", bus.ramWEN, 1'b1);
        RST = 1'b1;
        cyc(); mid();
        chkb("t5_rst_ramWEN", bus.ramWEN, 1'b0);
        chkb("t5_rst_fault", bus.fault, 1'b0);
        chkb("t5_rst_dwait", bus.dwait, 1'b1);
        bus.iREN = 1'b1; bus.iaddr = 32'h500;
        cyc(); RST = 1'b0;
        mid();
        chkb("t5_idle_ramWEN", bus.ramWEN, 1'b0);
        chkb("t5_idle_ramREN", bus.ramREN, 1'b0);
        cyc(); mid();
        chkb("t5_tie_ramWEN", bus.ramWEN, 1'b1);
        chkb("t5_tie_ramREN", bus.ramREN, 1'b0);
        chkb("t5_tie_iwait", bus.iwait, 1'b1);
        cyc(); bus.dWEN = 1'b0; bus.iREN = 1'b0;
        mid();
        chkb("t5_abort_ramWEN", bus.ramWEN, 1'b0);
        cyc();

        // T6: data read aborted during BUSY, pending fetch follows one IDLE later
        bus.dREN = 1'b1; bus.daddr = 32'h600; bus.iREN = 1'b1; bus.iaddr = 32'h700;
        tb_ramload = 32'h77;
        push(1'b0, 32'h77);
        mid();
        cyc(); mid();
        chkb("t6_gd_ramREN", bus.ramREN, 1'b1);
        chk("t6_gd_ramaddr", bus.ramaddr, 32'h600);
        chkb("t6_gd_iwait", bus.iwait, 1'b1);
        cyc(); bus.dREN = 1'b0;
        mid();
        chkb("t6_ab_ramREN", bus.ramREN, 1'b0);
        chkb("t6_ab_dwait", bus.dwait, 1'b0);
        cyc(); mid();
        chkb("t6_idle_ramREN", bus.ramREN, 1'b0);
        chkb("t6_idle_iwait", bus.iwait, 1'b1);
        chkb("t6_idle_fault", bus.fault, 1'b0);
        tb_ramstate = RS_ACCESS;
        cyc(); mid();
        chk("t6_gi_ramaddr", bus.ramaddr, 32'h700);
        sb_check("t6");
        cyc(); bus.iREN = 1'b0;

        // T7: RAM ERROR during an instruction grant faults immediately
        bus.iREN = 1'b1; bus.iaddr = 32'h800; tb_ramstate = RS_ERROR;
        push(1'b0, ERRWORD);
        mid();
        chk("t7_idle_iload", bus.iload, 32'h0);
        chkb("t7_idle_fault", bus.fault, 1'b0);
        cyc(); mid();
        chkb("t7_gi_iwait", bus.iwait, 1'b1);
        chkb("t7_gi_ramREN", bus.ramREN, 1'b1);
        cyc(); mid();
        sb_check("t7");
        chkb("t7_f_ramREN", bus.ramREN, 1'b0);
        chkb("t7_f_fault", bus.fault, 1'b1);
        cyc(); bus.iREN = 1'b0;
        mid();
        chk("t7_after_iload", bus.iload, 32'h0);
        chkb("t7_after_fault", bus.fault, 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
